// File: rtl/hazard_stall_ctrl_if.sv
// hazard_stall_ctrl_if: bundle between the pipeline and the hazard/stall controller.
//   master: the pipeline side. It drives the IF/ID fields and the ID_EX/EX_MEM hazard
//           sources, and it receives the control enables and the perf counters.
//   slave : the controller side. It uses the opposite directions.
//   Signals:
//     opcode_id, rs_id, rt_id           instruction in IF/ID
//     Memread_ex, Regwrite_ex, dst_ex   producer in EX
//     Memread_mem, dst_mem              producer in MEM
//     branch_taken_id                   branch comparator result in ID
//     muxcond, pcwrite, ifidwrite,      control outputs
//     ifidflush
//     stall_cnt, flush_cnt              saturating perf counters
interface hazard_stall_ctrl_if #(parameter int CNT_W = 16);
    logic [5:0]       opcode_id;
    logic [4:0]       rs_id;
    logic [4:0]       rt_id;
    logic             Memread_ex;
    logic             Regwrite_ex;
    logic [4:0]       dst_ex;
    logic             Memread_mem;
    logic [4:0]       dst_mem;
    logic             branch_taken_id;
    logic [5:0]       muxcond;
    logic             pcwrite;
    logic             ifidwrite;
    logic             ifidflush;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;
    modport master (
        output opcode_id, rs_id, rt_id, Memread_ex, Regwrite_ex, dst_ex,
               Memread_mem, dst_mem, branch_taken_id,
        input  muxcond, pcwrite, ifidwrite, ifidflush, stall_cnt, flush_cnt
    );
    modport slave (
        input  opcode_id, rs_id, rt_id, Memread_ex, Regwrite_ex, dst_ex,
               Memread_mem, dst_mem, branch_taken_id,
        output muxcond, pcwrite, ifidwrite, ifidflush, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: hazard/stall controller for the 5-stage pipeline. It feeds the ID_EX register.
//   clk : rising-edge clock
//   rst : synchronous, active-low reset. While it is low, the outputs are forced to the
//         reset pattern (bubble, hold PC and IF/ID, flush IF/ID).
//   bus : hazard_stall_ctrl_if.slave. It carries the IF/ID fields, the EX and MEM
//         producer info and the branch result in. It carries muxcond, pcwrite,
//         ifidwrite, ifidflush and the stall/flush counters out.
module hazard_stall_ctrl #(
    parameter int         CNT_W  = 16,
    parameter logic [5:0] BEQ_OP = 6'b000100,
    parameter logic [5:0] BNE_OP = 6'b000101,
    parameter logic [5:0] J_OP   = 6'b000010,
    parameter logic [5:0] JAL_OP = 6'b000011
) (
    input logic                clk,
    input logic                rst,
    hazard_stall_ctrl_if.slave bus
);
    typedef enum logic [1:0] {RUN = 2'd0, STALL2 = 2'd1, STALL1 = 2'd2} state_t;
    state_t           state, state_n;
    logic             is_jmp, uses_rs, uses_rt, is_br, hit_ex, hit_mem;
    logic             lu, br_alu, br_ld_ex, br_ld_mem, stall, flush, go;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;
    assign is_jmp  = bus.opcode_id == J_OP || bus.opcode_id == JAL_OP;
    assign uses_rs = !is_jmp;
    assign uses_rt = bus.opcode_id == 6'b000000 || bus.opcode_id == BEQ_OP ||
                     bus.opcode_id == BNE_OP || bus.opcode_id == 6'b101011;
    assign is_br   = bus.opcode_id == BEQ_OP || bus.opcode_id == BNE_OP;
    // $0 is hardwired to zero, so it can never be a producer.
    assign hit_ex  = bus.dst_ex != 5'd0 &&
                     ((uses_rs && bus.rs_id == bus.dst_ex) || (uses_rt && bus.rt_id == bus.dst_ex));
    assign hit_mem = bus.dst_mem != 5'd0 &&
                     ((uses_rs && bus.rs_id == bus.dst_mem) || (uses_rt && bus.rt_id == bus.dst_mem));
    assign lu        = bus.Memread_ex && hit_ex;
    assign br_alu    = is_br && bus.Regwrite_ex && !bus.Memread_ex && hit_ex;
    assign br_ld_ex  = is_br && bus.Memread_ex && hit_ex;
    assign br_ld_mem = is_br && bus.Memread_mem && hit_mem;
    // Every non-RUN state stalls unconditionally. An illegal encoding stalls once and then returns to RUN.
    always_comb begin
        state_n = RUN;
        stall   = 1'b1;
        flush   = 1'b0;
        case (state)
            RUN: begin
                stall   = lu || br_alu || br_ld_ex || br_ld_mem;
                flush   = !stall && ((is_br && bus.branch_taken_id) || is_jmp);
                state_n = br_ld_ex ? STALL1 : RUN;
            end
            STALL2:  state_n = STALL1;
            default: state_n = RUN;
        endcase
    end
    assign go            = rst && !stall;
    assign bus.muxcond   = go ? 6'd1 : 6'd0;
    assign bus.pcwrite   = go;
    assign bus.ifidwrite = go;
    assign bus.ifidflush = !rst || flush;
    assign bus.stall_cnt = stall_cnt;
    assign bus.flush_cnt = flush_cnt;
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= RUN;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            state <= state_n;
            if (stall && !(&stall_cnt)) stall_cnt <= stall_cnt + CNT_W'(1);
            if (flush && !(&flush_cnt)) flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb_hazard_stall_ctrl: directed and random checks of hazard_stall_ctrl against a behavioural model.
//   It runs a CNT_W=16 instance and a CNT_W=4 instance side by side on the same inputs.
//   The small instance exercises counter saturation.
module tb_hazard_stall_ctrl;
    localparam logic [5:0] RT = 6'b000000, BEQ = 6'b000100, BNE = 6'b000101;
    localparam logic [5:0] J = 6'b000010, JAL = 6'b000011, SW = 6'b101011, LW = 6'b100011;
    localparam logic [8:0] NORM = {6'd1, 3'b110}, FLSH = {6'd1, 3'b111};
    localparam logic [8:0] STL = 9'd0, RSTP = 9'd1;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;
    hazard_stall_ctrl_if #(.CNT_W(16)) bus ();
    hazard_stall_ctrl_if #(.CNT_W(4))  bus4 ();
    hazard_stall_ctrl #(.CNT_W(16)) dut  (.clk(clk), .rst(rst), .bus(bus.slave));
    hazard_stall_ctrl #(.CNT_W(4))  dut4 (.clk(clk), .rst(rst), .bus(bus4.slave));
    assign bus4.opcode_id       = bus.opcode_id;
    assign bus4.rs_id           = bus.rs_id;
    assign bus4.rt_id           = bus.rt_id;
    assign bus4.Memread_ex      = bus.Memread_ex;
    assign bus4.Regwrite_ex     = bus.Regwrite_ex;
    assign bus4.dst_ex          = bus.dst_ex;
    assign bus4.Memread_mem     = bus.Memread_mem;
    assign bus4.dst_mem         = bus.dst_mem;
    assign bus4.branch_taken_id = bus.branch_taken_id;
    int checks = 0, errors = 0;
    // Model: pend = number of forced stall cycles still owed after a branch-on-load-in-EX.
    int pend = 0, scnt = 0, fcnt = 0, scnt4 = 0, fcnt4 = 0;
    logic e_stall, e_flush, e_brld;
    logic [8:0] exp_out;
    function automatic logic hit(logic [4:0] d, logic urs, logic urt);
        return d != 5'd0 && ((urs && bus.rs_id == d) || (urt && bus.rt_id == d));
    endfunction
    function automatic logic [8:0] act();
        return {bus.muxcond, bus.pcwrite, bus.ifidwrite, bus.ifidflush};
    endfunction
    function automatic logic [8:0] act4();
        return {bus4.muxcond, bus4.pcwrite, bus4.ifidwrite, bus4.ifidflush};
    endfunction
    task automatic settle();
        logic urs, urt, br, jmp, haz;
        #1;
        jmp = bus.opcode_id == J || bus.opcode_id == JAL;
        urs = !jmp;
        urt = bus.opcode_id inside {RT, BEQ, BNE, SW};
        br  = bus.opcode_id inside {BEQ, BNE};
        haz = (bus.Memread_ex && hit(bus.dst_ex, urs, urt)) ||
              (br && bus.Regwrite_ex && hit(bus.dst_ex, urs, urt)) ||
              (br && bus.Memread_mem && hit(bus.dst_mem, urs, urt));
        e_stall = rst && (pend > 0 || haz);
        e_flush = !rst || (!e_stall && ((br && bus.branch_taken_id) || jmp));
        e_brld  = pend == 0 && br && bus.Memread_ex && hit(bus.dst_ex, urs, urt);
        exp_out = {(rst && !e_stall) ? 6'd1 : 6'd0, rst && !e_stall, rst && !e_stall, e_flush};
    endtask
    task automatic tick();
        @(posedge clk);
        if (!rst) begin
            pend = 0; scnt = 0; fcnt = 0; scnt4 = 0; fcnt4 = 0;
        end else begin
            if (e_stall) begin
                scnt  = scnt < 65535 ? scnt + 1 : scnt;
                scnt4 = scnt4 < 15 ? scnt4 + 1 : scnt4;
            end
            if (e_flush) begin
                fcnt  = fcnt < 65535 ? fcnt + 1 : fcnt;
                fcnt4 = fcnt4 < 15 ? fcnt4 + 1 : fcnt4;
            end
            pend = pend > 0 ? pend - 1 : (e_brld ? 1 : 0);
        end
        @(negedge clk);
    endtask
    task automatic clear_inputs();
        bus.opcode_id = RT; bus.rs_id = 0; bus.rt_id = 0; bus.Memread_ex = 0;
        bus.Regwrite_ex = 0; bus.dst_ex = 0; bus.Memread_mem = 0; bus.dst_mem = 0;
        bus.branch_taken_id = 0;
    endtask
    task automatic test_reset();
        clear_inputs();
        rst = 1'b0;
        bus.Memread_ex = 1; bus.dst_ex = 10; bus.rs_id = 10;
        for (int i = 0; i < 2; i++) begin
            settle();
            checks++;
            if (act() !== RSTP) begin
                errors++; $display("FAIL reset_out[%0d]: got %b want %b", i, act(), RSTP);
            end
            tick();
        end
        checks++;
        if (bus.stall_cnt !== 16'd0 || bus.flush_cnt !== 16'd0 || bus4.stall_cnt !== 4'd0 || bus4.flush_cnt !== 4'd0) begin
            errors++; $display("FAIL reset_cnt: got %0h/%0h/%0h/%0h want 0", bus.stall_cnt, bus.flush_cnt, bus4.stall_cnt, bus4.flush_cnt);
        end
        rst = 1'b1;
        clear_inputs();
        settle();
        checks++;
        if (act() !== NORM) begin
            errors++; $display("FAIL reset_release: got %b want %b", act(), NORM);
        end
        tick();
    endtask
    task automatic test_load_use();
        clear_inputs();
        bus.Memread_ex = 1; bus.dst_ex = 10; bus.rs_id = 10;
        settle();
        checks++;
        if (act() !== STL) begin
            errors++; $display("FAIL load_use_stall: got %b want %b", act(), STL);
        end
        tick();
        bus.Memread_ex = 0;
        settle();
        checks++;
        if (act() !== NORM) begin
            errors++; $display("FAIL load_use_resume: got %b want %b", act(), NORM);
        end
        tick();
        checks++;
        if (bus.stall_cnt !== 16'd1) begin
            errors++; $display("FAIL load_use_cnt: got %0d want 1", bus.stall_cnt);
        end
    endtask
    task automatic test_zero_reg();
        clear_inputs();
        bus.Memread_ex = 1; bus.dst_ex = 0; bus.rs_id = 0;
        settle();
        checks++;
        if (act() !== NORM) begin
            errors++; $display("FAIL zero_reg_out: got %b want %b", act(), NORM);
        end
        tick();
        checks++;
        if (bus.stall_cnt !== 16'd1) begin
            errors++; $display("FAIL zero_reg_cnt: got %0d want 1", bus.stall_cnt);
        end
    endtask
    task automatic test_branch_load();
        clear_inputs();
        bus.opcode_id = BEQ; bus.rt_id = 11; bus.Memread_ex = 1; bus.dst_ex = 11;
        settle();
        checks++;
        if (act() !== STL) begin
            errors++; $display("FAIL br_load_stall1: got %b want %b", act(), STL);
        end
        tick();
        clear_inputs();
        settle();
        checks++;
        if (act() !== STL) begin
            errors++; $display("FAIL br_load_stall2: got %b want %b", act(), STL);
        end
        tick();
        bus.opcode_id = BEQ; bus.rt_id = 11; bus.dst_ex = 11; bus.branch_taken_id = 1;
        settle();
        checks++;
        if (act() !== FLSH) begin
            errors++; $display("FAIL br_load_flush: got %b want %b", act(), FLSH);
        end
        tick();
        clear_inputs();
        settle();
        checks++;
        if (act() !== NORM) begin
            errors++; $display("FAIL br_load_after: got %b want %b", act(), NORM);
        end
        checks++;
        if (bus.stall_cnt !== 16'd3 || bus.flush_cnt !== 16'd1) begin
            errors++; $display("FAIL br_load_cnt: got %0d/%0d want 3/1", bus.stall_cnt, bus.flush_cnt);
        end
        tick();
    endtask
    task automatic test_stall_beats_flush();
        clear_inputs();
        bus.opcode_id = BEQ; bus.branch_taken_id = 1; bus.Regwrite_ex = 1; bus.dst_ex = 3; bus.rs_id = 3;
        settle();
        checks++;
        if (act() !== STL) begin
            errors++; $display("FAIL stall_beats_flush: got %b want %b", act(), STL);
        end
        tick();
        clear_inputs();
        bus.opcode_id = BNE; bus.branch_taken_id = 1; bus.Memread_mem = 1; bus.dst_mem = 4; bus.rt_id = 4;
        settle();
        checks++;
        if (act() !== STL) begin
            errors++; $display("FAIL stall_beats_flush_mem: got %b want %b", act(), STL);
        end
        tick();
    endtask
    task automatic test_jump();
        clear_inputs();
        bus.opcode_id = J; bus.Memread_ex = 1; bus.dst_ex = 7; bus.rs_id = 7; bus.rt_id = 7;
        settle();
        checks++;
        if (act() !== FLSH) begin
            errors++; $display("FAIL jump_flush: got %b want %b", act(), FLSH);
        end
        tick();
        bus.opcode_id = JAL;
        settle();
        checks++;
        if (act() !== FLSH) begin
            errors++; $display("FAIL jal_flush: got %b want %b", act(), FLSH);
        end
        tick();
        checks++;
        if (bus.stall_cnt !== 16'(scnt) || bus.flush_cnt !== 16'(fcnt)) begin
            errors++; $display("FAIL jump_cnt: got %0d/%0d want %0d/%0d", bus.stall_cnt, bus.flush_cnt, scnt, fcnt);
        end
    endtask
    task automatic test_reset_mid_stall();
        clear_inputs();
        bus.opcode_id = BNE; bus.rs_id = 5; bus.Memread_ex = 1; bus.dst_ex = 5;
        settle();
        checks++;
        if (act() !== STL) begin
            errors++; $display("FAIL mid_stall_enter: got %b want %b", act(), STL);
        end
        tick();
        clear_inputs();
        rst = 1'b0;
        settle();
        checks++;
        if (act() !== RSTP) begin
            errors++; $display("FAIL mid_stall_reset: got %b want %b", act(), RSTP);
        end
        tick();
        rst = 1'b1;
        settle();
        checks++;
        if (act() !== NORM || bus.stall_cnt !== 16'd0) begin
            errors++; $display("FAIL mid_stall_release: got %b cnt %0d want %b cnt 0", act(), bus.stall_cnt, NORM);
        end
        tick();
    endtask
    task automatic test_saturation();
        clear_inputs();
        bus.Memread_ex = 1; bus.dst_ex = 9; bus.rs_id = 9;
        for (int i = 0; i < 20; i++) begin
            settle();
            tick();
        end
        checks++;
        if (bus4.stall_cnt !== 4'hF) begin
            errors++; $display("FAIL sat_cnt4: got %0h want f", bus4.stall_cnt);
        end
        checks++;
        if (bus.stall_cnt !== 16'd20) begin
            errors++; $display("FAIL sat_cnt16: got %0d want 20", bus.stall_cnt);
        end
    endtask
    task automatic test_random();
        logic [5:0] ops [7] = '{RT, BEQ, BNE, J, JAL, SW, LW};
        for (int i = 0; i < 500; i++) begin
            rst = $urandom_range(0, 24) != 0;
            bus.opcode_id = $urandom_range(0, 9) == 0 ? 6'($urandom) : ops[$urandom_range(0, 6)];
            bus.rs_id = 5'($urandom_range(0, 3));
            bus.rt_id = 5'($urandom_range(0, 3));
            bus.Memread_ex = $urandom_range(0, 3) == 0;
            bus.Regwrite_ex = 1'($urandom);
            bus.dst_ex = 5'($urandom_range(0, 3));
            bus.Memread_mem = $urandom_range(0, 3) == 0;
            bus.dst_mem = 5'($urandom_range(0, 3));
            bus.branch_taken_id = 1'($urandom);
            settle();
            checks++;
            if (act() !== exp_out || act4() !== exp_out) begin
                errors++; $display("FAIL rand_out[%0d]: got %b/%b want %b", i, act(), act4(), exp_out);
            end
            tick();
            checks++;
            if (bus.stall_cnt !== 16'(scnt) || bus.flush_cnt !== 16'(fcnt) ||
                bus4.stall_cnt !== 4'(scnt4) || bus4.flush_cnt !== 4'(fcnt4)) begin
                errors++; $display("FAIL rand_cnt[%0d]: got %0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d", i,
                    bus.stall_cnt, bus.flush_cnt, bus4.stall_cnt, bus4.flush_cnt, scnt, fcnt, scnt4, fcnt4);
            end
        end
    endtask
    initial begin
        rst = 1'b0;
        clear_inputs();
        @(negedge clk);
        test_reset();
        test_load_use();
        test_zero_reg();
        test_branch_load();
        test_stall_beats_flush();
        test_jump();
        test_reset_mid_stall();
        test_saturation();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
